// File: rtl/ac_pkg.sv
// Shared air-conditioner definitions: fan speed-level code, duty table and
// the fan driver state encoding.
package ac_pkg;

    typedef enum logic [1:0] {
        LVL1 = 2'b00,
        LVL2 = 2'b01,
        LVL3 = 2'b10,
        LVL4 = 2'b11
    } speed_lvl_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KICK = 3'd1;
    localparam logic [2:0] S_RAMP = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;

    localparam logic [7:0] KICK_DUTY = 8'd255;

    // Indexed by speed level: lvl1=64, lvl2=128, lvl3=192, lvl4=255.
    localparam logic [3:0][7:0] LVL_DUTY = {8'd255, 8'd192, 8'd128, 8'd64};

    // Move cur toward goal by at most step, landing exactly on goal.
    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] goal,
                                               input logic [7:0] step);
        logic [7:0] diff;
        if (goal > cur) begin
            diff = goal - cur;
            return (diff > step) ? cur + step : goal;
        end else begin
            diff = cur - goal;
            return (diff > step) ? cur - step : goal;
        end
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, period-boundary duty latch
// and the registered gate output.
module pwm_timebase #(
    parameter int PRESCALE = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_cur,
    output logic       period_end,
    output logic       pwm_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_q;

    assign tick       = (presc == PW'(PRESCALE - 1));
    assign period_end = tick && (pwm_cnt == 8'hFF);

    // duty_q only moves at the period boundary so a period never gets cut short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
            duty_q  <= '0;
            pwm_out <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            if (period_end)
                duty_q <= duty_cur;
            pwm_out <= (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt < duty_q);
        end
    end

endmodule

// File: rtl/fan_pwm_drv.sv
// Fan motor driver: spin-up kick, rate-limited ramping between speed levels
// and soft stop, feeding the PWM timebase.
//
//  state  | meaning
//  IDLE   | fan off, duty 0, waiting for fan_en
//  KICK   | full duty spin-up from standstill
//  RAMP   | stepping duty toward the level target
//  RUN    | duty at target, steady
//  STOP   | stepping duty down to 0 (rotor coasting)
module fan_pwm_drv
    import ac_pkg::*;
#(
    parameter int PRESCALE     = 50,
    parameter int KICK_PERIODS = 64,
    parameter int RAMP_PERIODS = 4,
    parameter int RAMP_STEP    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fan_en,
    input  logic [1:0] speed_lvl,
    output logic       pwm_out,
    output logic [7:0] duty_cur,
    output logic       fan_running,
    output logic       busy
);

    localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam int SW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS - 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(RAMP_PERIODS - 1);
    localparam logic [7:0]    STEP      = 8'(RAMP_STEP);

    logic [2:0]    state;
    logic [KW-1:0] kick_cnt;
    logic [SW-1:0] step_cnt;
    logic          period_end;
    logic          step_evt;
    logic [7:0]    target;
    speed_lvl_t    lvl;

    assign lvl      = speed_lvl_t'(speed_lvl);
    assign target   = LVL_DUTY[lvl];
    assign step_evt = period_end && (step_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            duty_cur <= '0;
            kick_cnt <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    duty_cur <= '0;
                    if (fan_en) begin
                        state    <= S_KICK;
                        duty_cur <= KICK_DUTY;
                        kick_cnt <= KICK_LOAD;
                    end
                end
                S_KICK: begin
                    if (!fan_en) begin
                        state    <= S_STOP;
                        step_cnt <= STEP_LOAD;
                    end else if (period_end) begin
                        if (kick_cnt == '0) begin
                            state    <= S_RAMP;
                            step_cnt <= STEP_LOAD;
                        end else begin
                            kick_cnt <= kick_cnt - 1'b1;
                        end
                    end
                end
                S_RAMP: begin
                    if (!fan_en) begin
                        state    <= S_STOP;
                        step_cnt <= STEP_LOAD;
                    end else if (duty_cur == target) begin
                        state <= S_RUN;
                    end else begin
                        if (step_evt)
                            duty_cur <= step_toward(duty_cur, target, STEP);
                        if (period_end)
                            step_cnt <= step_evt ? STEP_LOAD : step_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!fan_en) begin
                        state    <= S_STOP;
                        step_cnt <= STEP_LOAD;
                    end else if (duty_cur != target) begin
                        state    <= S_RAMP;
                        step_cnt <= STEP_LOAD;
                    end
                end
                S_STOP: begin
                    // At zero duty the rotor is treated as stopped; a restart goes through KICK.
                    if (duty_cur == '0) begin
                        state <= S_IDLE;
                    end else if (fan_en) begin
                        state    <= S_RAMP;
                        step_cnt <= STEP_LOAD;
                    end else begin
                        if (step_evt)
                            duty_cur <= step_toward(duty_cur, 8'd0, STEP);
                        if (period_end)
                            step_cnt <= step_evt ? STEP_LOAD : step_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    duty_cur <= '0;
                end
            endcase
        end
    end

    assign fan_running = (state != S_IDLE);
    assign busy        = (state == S_KICK) || (state == S_RAMP) || (state == S_STOP);

    pwm_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty_cur  (duty_cur),
        .period_end(period_end),
        .pwm_out   (pwm_out)
    );

endmodule

// File: tb/tb_fan_pwm_drv.sv
// Directed bench for fan_pwm_drv with a 256-clk PWM period and fast kick/ramp settings.
module tb_fan_pwm_drv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fan_en = 1'b0;
    logic [1:0] speed_lvl = 2'b00;
    logic       pwm_out;
    logic [7:0] duty_cur;
    logic       fan_running;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    fan_pwm_drv #(
        .PRESCALE    (1),
        .KICK_PERIODS(2),
        .RAMP_PERIODS(1),
        .RAMP_STEP   (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fan_en     (fan_en),
        .speed_lvl  (speed_lvl),
        .pwm_out    (pwm_out),
        .duty_cur   (duty_cur),
        .fan_running(fan_running),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_change(input logic [7:0] old, input int limit,
                               output logic [7:0] val, output int dt);
        dt = 0;
        while (duty_cur === old && dt < limit) begin
            @(posedge clk);
            #1;
            dt++;
        end
        val = duty_cur;
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step_clk(1);
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fan_en = 1'b1; speed_lvl = 2'b00;
        step_clk(5);
        n_checks++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out); else n_pass++;
        n_checks++; if (duty_cur !== 8'd0) $display("FAIL reset_duty got %0d want 0", duty_cur); else n_pass++;
        n_checks++; if (fan_running !== 1'b0) $display("FAIL reset_running got %b want 0", fan_running); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        step_clk(1);
        n_checks++; if (duty_cur !== 8'd255) $display("FAIL kick_entry_duty got %0d want 255", duty_cur); else n_pass++;
        n_checks++; if (busy !== 1'b1 || fan_running !== 1'b1)
            $display("FAIL kick_entry_flags got busy=%b run=%b want 1/1", busy, fan_running); else n_pass++;
    endtask

    task automatic test_start();
        logic [7:0] v;
        int dt, hi;
        logic [7:0] exp_v [3] = '{8'd191, 8'd127, 8'd64};
        int exp_dt [3] = '{767, 256, 256};
        logic [7:0] old = 8'd255;
        for (int i = 0; i < 3; i++) begin
            wait_change(old, 1000, v, dt);
            n_checks++; if (v !== exp_v[i]) $display("FAIL start_step%0d got %0d want %0d", i, v, exp_v[i]); else n_pass++;
            n_checks++; if (dt != exp_dt[i]) $display("FAIL start_gap%0d got %0d want %0d", i, dt, exp_dt[i]); else n_pass++;
            old = v;
        end
        step_clk(1);
        n_checks++; if (busy !== 1'b0 || fan_running !== 1'b1)
            $display("FAIL start_run got busy=%b run=%b want 0/1", busy, fan_running); else n_pass++;
        step_clk(300);
        count_high(hi);
        n_checks++; if (hi != 64) $display("FAIL start_highcnt got %0d want 64", hi); else n_pass++;
    endtask

    task automatic test_level_up();
        logic [7:0] v;
        int dt, hi;
        logic [7:0] exp_v [3] = '{8'd128, 8'd192, 8'd255};
        logic [7:0] old = 8'd64;
        speed_lvl = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_change(old, 600, v, dt);
            n_checks++; if (v !== exp_v[i]) $display("FAIL up_step%0d got %0d want %0d", i, v, exp_v[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (dt != 256) $display("FAIL up_gap%0d got %0d want 256", i, dt); else n_pass++;
            end
            old = v;
        end
        step_clk(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL up_run got busy=%b want 0", busy); else n_pass++;
        step_clk(600);
        count_high(hi);
        n_checks++; if (hi != 256) $display("FAIL up_highcnt got %0d want 256", hi); else n_pass++;
    endtask

    task automatic test_stop();
        logic [7:0] v;
        int dt, hi;
        logic [7:0] exp_v [4] = '{8'd191, 8'd127, 8'd63, 8'd0};
        logic [7:0] old = 8'd255;
        fan_en = 1'b0;
        step_clk(1);
        n_checks++; if (busy !== 1'b1) $display("FAIL stop_entry got busy=%b want 1", busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            wait_change(old, 600, v, dt);
            n_checks++; if (v !== exp_v[i]) $display("FAIL stop_step%0d got %0d want %0d", i, v, exp_v[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (dt != 256) $display("FAIL stop_gap%0d got %0d want 256", i, dt); else n_pass++;
            end
            old = v;
        end
        step_clk(1);
        n_checks++; if (fan_running !== 1'b0 || busy !== 1'b0)
            $display("FAIL stop_idle got run=%b busy=%b want 0/0", fan_running, busy); else n_pass++;
        step_clk(300);
        count_high(hi);
        n_checks++; if (hi != 0) $display("FAIL stop_highcnt got %0d want 0", hi); else n_pass++;
    endtask

    task automatic test_reenable();
        logic [7:0] v;
        int dt;
        int guard = 0;
        fan_en = 1'b1; speed_lvl = 2'b11;
        step_clk(1);
        while (busy === 1'b1 && guard < 1000) begin
            step_clk(1);
            guard++;
        end
        n_checks++; if (busy !== 1'b0 || duty_cur !== 8'd255)
            $display("FAIL reen_run255 got busy=%b duty=%0d want 0/255", busy, duty_cur); else n_pass++;
        fan_en = 1'b0;
        wait_change(8'd255, 600, v, dt);
        wait_change(v, 600, v, dt);
        n_checks++; if (v !== 8'd127) $display("FAIL reen_stop127 got %0d want 127", v); else n_pass++;
        fan_en = 1'b1; speed_lvl = 2'b01;
        step_clk(1);
        n_checks++; if (busy !== 1'b1 || duty_cur !== 8'd127)
            $display("FAIL reen_ramp got busy=%b duty=%0d want 1/127", busy, duty_cur); else n_pass++;
        wait_change(8'd127, 600, v, dt);
        n_checks++; if (v !== 8'd128) $display("FAIL reen_step got %0d want 128", v); else n_pass++;
        step_clk(1);
        n_checks++; if (busy !== 1'b0 || duty_cur !== 8'd128)
            $display("FAIL reen_run got busy=%b duty=%0d want 0/128", busy, duty_cur); else n_pass++;
    endtask

    task automatic test_periods_and_reset();
        int cnt [6] = '{0, 0, 0, 0, 0, 0};
        int exp_cnt [6] = '{0, 256, 256, 256, 191, 192};
        rst_n = 1'b0; fan_en = 1'b1; speed_lvl = 2'b00;
        step_clk(3);
        rst_n = 1'b1;
        for (int e = 1; e <= 1600; e++) begin
            step_clk(1);
            if (e <= 1536 && pwm_out === 1'b1) cnt[(e - 1) / 256]++;
            if (e == 900) speed_lvl = 2'b10;
            if (e == 1030) begin
                n_checks++; if (duty_cur !== 8'd192 || busy !== 1'b0)
                    $display("FAIL mid_lvl got duty=%0d busy=%b want 192/0", duty_cur, busy); else n_pass++;
            end
            if (e == 1400) speed_lvl = 2'b00;
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (cnt[k] != exp_cnt[k])
                $display("FAIL period%0d_highcnt got %0d want %0d", k, cnt[k], exp_cnt[k]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b1 || duty_cur !== 8'd128)
            $display("FAIL mid_ramp got busy=%b duty=%0d want 1/128", busy, duty_cur); else n_pass++;
        rst_n = 1'b0;
        step_clk(1);
        n_checks++; if (pwm_out !== 1'b0 || duty_cur !== 8'd0 || fan_running !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset got pwm=%b duty=%0d run=%b busy=%b want all 0",
                     pwm_out, duty_cur, fan_running, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_up();
        test_stop();
        test_reenable();
        test_periods_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
